// File: rtl/fpu_seq_pkg.sv
// Shared definitions for the FPU issue sequencer: FSM encoding, FPU op codes
// and the per-operation latency lookup.
`timescale 1ns/1ps
package fpu_seq_pkg;

   // FSM encoding. The enum is the readable view for waveforms and checkers.
   // The localparams are the constants that the RTL compares against.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // FPU operation codes. Bit 4 set marks the operation as an FPU operation.
   localparam logic [4:0] FADD   = 5'b10000;
   localparam logic [4:0] FSUB   = 5'b10001;
   localparam logic [4:0] FMUL   = 5'b10010;
   localparam logic [4:0] FDIV   = 5'b10011;
   localparam logic [4:0] FSQRT  = 5'b10100;
   localparam logic [4:0] FLE    = 5'b10101;
   localparam logic [4:0] FLT    = 5'b10110;
   localparam logic [4:0] FEQ    = 5'b10111;
   localparam logic [4:0] FSGNJ  = 5'b11000;
   localparam logic [4:0] FSGNJN = 5'b11001;
   localparam logic [4:0] FSGNJX = 5'b11010;
   localparam logic [4:0] FCVTSW = 5'b11100;
   localparam logic [4:0] FCVTWS = 5'b11101;

   // Latency in cycles for an op code. Compares, sign injection and any
   // unlisted FPU code fall through to the short misc latency.
   function automatic logic [3:0] lat_of(
      input logic [4:0] cont,
      input logic [3:0] add_l,
      input logic [3:0] mul_l,
      input logic [3:0] div_l,
      input logic [3:0] sqrt_l,
      input logic [3:0] cvt_l,
      input logic [3:0] misc_l
   );
      case (cont)
         FADD, FSUB:     lat_of = add_l;
         FMUL:           lat_of = mul_l;
         FDIV:           lat_of = div_l;
         FSQRT:          lat_of = sqrt_l;
         FCVTSW, FCVTWS: lat_of = cvt_l;
         default:        lat_of = misc_l;
      endcase
   endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// 4-bit down counter that times one FPU operation. It loads the remaining
// cycle count at issue, decrements while the op is in flight, and flags zero.
`timescale 1ns/1ps
module fpu_lat_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic [3:0] cnt,
   output logic       zero
);

   // Priority order is clear, then load, then decrement. The count saturates at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= 4'd0;
      end else if (clr) begin
         cnt <= 4'd0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != 4'd0)) begin
         cnt <= cnt - 4'd1;
      end
   end

   // Zero means the op retires at the next edge when the sequencer is busy.
   always_comb begin
      zero = (cnt == 4'd0);
   end

endmodule

// File: rtl/fpu_sequencer.sv
// Multi-cycle issue controller for the FPU datapath. It holds one operation's
// operands and code stable at the FPU and times its latency. It captures the
// result and offers it to writeback. It stalls the pipeline while it is occupied.
//
// Handshakes:
//   request : an op transfers on a rising edge when req_valid & req_cont[4] &
//             req_ready & ~flush. req_ready is combinational and does not
//             depend on req_valid. Codes with bit 4 clear are not FPU ops and
//             are ignored entirely.
//   result  : res_valid/res_data/res_rd are held stable until writeback
//             consumes them on an edge with wb_ready=1. A new op may be
//             accepted on that same edge. flush kills both directions.
`timescale 1ns/1ps
module fpu_sequencer
   import fpu_seq_pkg::*;
#(
   parameter int unsigned ADD_LAT  = 3,
   parameter int unsigned MUL_LAT  = 2,
   parameter int unsigned DIV_LAT  = 10,
   parameter int unsigned SQRT_LAT = 7,
   parameter int unsigned CVT_LAT  = 2,
   parameter int unsigned MISC_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [4:0]  req_cont,
   input  logic [31:0] req_x1,
   input  logic [31:0] req_x2,
   input  logic [4:0]  req_rd,
   output logic        req_ready,
   output logic [31:0] fpu_x1,
   output logic [31:0] fpu_x2,
   output logic [4:0]  fpu_cont,
   input  logic [31:0] fpu_y,
   output logic        res_valid,
   output logic [31:0] res_data,
   output logic [4:0]  res_rd,
   input  logic        wb_ready,
   input  logic        flush,
   output logic        stall,
   output logic [1:0]  state_dbg
);

   localparam logic [3:0] ADD_L  = 4'(ADD_LAT);
   localparam logic [3:0] MUL_L  = 4'(MUL_LAT);
   localparam logic [3:0] DIV_L  = 4'(DIV_LAT);
   localparam logic [3:0] SQRT_L = 4'(SQRT_LAT);
   localparam logic [3:0] CVT_L  = 4'(CVT_LAT);
   localparam logic [3:0] MISC_L = 4'(MISC_LAT);

   logic [1:0]  state;
   logic [1:0]  state_nx;
   logic [31:0] x1_q;
   logic [31:0] x2_q;
   logic [4:0]  cont_q;
   logic [4:0]  rd_q;
   logic [31:0] res_data_q;

   logic        is_fpu;
   logic        accept;
   logic        retire;
   logic [3:0]  cnt;
   logic        cnt_zero;
   logic [3:0]  load_val;

   // Handshake terms, stall and the next-count value at issue.
   always_comb begin
      is_fpu    = req_cont[4];
      req_ready = (state == ST_IDLE) || ((state == ST_DONE) && wb_ready);
      accept    = req_valid && is_fpu && req_ready && !flush;
      retire    = (state == ST_BUSY) && cnt_zero;
      stall     = (state == ST_BUSY) ||
                  ((state == ST_DONE) && !wb_ready) ||
                  (req_valid && is_fpu && !req_ready);
      load_val  = lat_of(req_cont, ADD_L, MUL_L, DIV_L, SQRT_L, CVT_L, MISC_L) - 4'd1;
   end

   // Next state. flush overrides everything. DONE can reload directly to BUSY.
   always_comb begin
      state_nx = state;
      if (flush) begin
         state_nx = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (accept) state_nx = ST_BUSY;
            ST_BUSY: if (cnt_zero) state_nx = ST_DONE;
            ST_DONE: begin
               if (accept) begin
                  state_nx = ST_BUSY;
               end else if (wb_ready) begin
                  state_nx = ST_IDLE;
               end
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   // State, operand/tag latches and the captured result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         x1_q       <= 32'd0;
         x2_q       <= 32'd0;
         cont_q     <= 5'd0;
         rd_q       <= 5'd0;
         res_data_q <= 32'd0;
      end else begin
         state <= state_nx;
         if (accept) begin
            x1_q   <= req_x1;
            x2_q   <= req_x2;
            cont_q <= req_cont;
            rd_q   <= req_rd;
         end else if (state_nx == ST_IDLE) begin
            // An idle FPU sees a null op code.
            cont_q <= 5'd0;
         end
         if (retire && !flush) begin
            res_data_q <= fpu_y;
         end
      end
   end

   fpu_lat_counter u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (flush),
      .load     (accept),
      .load_val (load_val),
      .dec      (state == ST_BUSY),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   // Output mapping. res_valid is a pure function of the state register.
   always_comb begin
      fpu_x1    = x1_q;
      fpu_x2    = x2_q;
      fpu_cont  = cont_q;
      res_rd    = rd_q;
      res_data  = res_data_q;
      res_valid = (state == ST_DONE);
      state_dbg = state;
   end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed bench for fpu_sequencer: hand-computed latencies and results,
// writeback scoreboard, backpressure, flush and asynchronous reset.
`timescale 1ns/1ps
module tb_fpu_sequencer;
   import fpu_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid;
   logic [4:0]  req_cont;
   logic [31:0] req_x1;
   logic [31:0] req_x2;
   logic [4:0]  req_rd;
   logic        req_ready;
   logic [31:0] fpu_x1;
   logic [31:0] fpu_x2;
   logic [4:0]  fpu_cont;
   logic [31:0] fpu_y;
   logic        res_valid;
   logic [31:0] res_data;
   logic [4:0]  res_rd;
   logic        wb_ready;
   logic        flush;
   logic        stall;
   logic [1:0]  state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   logic [36:0] exp_q[$];   // {rd, data} of results still owed to writeback

   fpu_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_cont  (req_cont),
      .req_x1    (req_x1),
      .req_x2    (req_x2),
      .req_rd    (req_rd),
      .req_ready (req_ready),
      .fpu_x1    (fpu_x1),
      .fpu_x2    (fpu_x2),
      .fpu_cont  (fpu_cont),
      .fpu_y     (fpu_y),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_rd    (res_rd),
      .wb_ready  (wb_ready),
      .flush     (flush),
      .stall     (stall),
      .state_dbg (state_dbg)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one edge. Return 1 ns after it, so inputs change away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = 1'b0;
      req_cont  = 5'd0;
      req_x1    = 32'd0;
      req_x2    = 32'd0;
      req_rd    = 5'd0;
      fpu_y     = 32'd0;
      wb_ready  = 1'b1;
      flush     = 1'b0;
   endtask

   // Compare the presented result against the oldest scoreboard entry.
   task automatic consume(input string tag);
      logic [36:0] e;
      check({tag, "_valid"}, res_valid, 1);
      if (exp_q.size() == 0) begin
         check({tag, "_sb_has_entry"}, 0, 1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_data"}, res_data, e[31:0]);
         check({tag, "_rd"}, res_rd, e[36:32]);
      end
   endtask

   // Issue one op, then wait (bounded) for its result. Check the latency, the
   // stall cycles and operand hold. If a result is presented with wb_ready=1,
   // it retires on the issue edge.
   task automatic run_op(input logic [4:0] cont, input logic [31:0] x1, input logic [31:0] x2,
                         input logic [4:0] rd, input logic [31:0] y, input int lat,
                         input string tag);
      int edges;
      int stalls;
      if (res_valid && wb_ready) consume({tag, "_prev"});
      req_valid = 1'b1;
      req_cont  = cont;
      req_x1    = x1;
      req_x2    = x2;
      req_rd    = rd;
      fpu_y     = y;
      #1;
      check({tag, "_req_ready"}, req_ready, 1);
      exp_q.push_back({rd, y});
      tick();
      req_valid = 1'b0;
      req_x1    = ~x1;
      req_x2    = ~x2;
      #1;
      check({tag, "_busy_after_accept"}, state_dbg, ST_BUSY);
      check({tag, "_cont_issued"}, fpu_cont, cont);
      edges  = 0;
      stalls = 0;
      while (!res_valid && edges < 20) begin
         if (stall) stalls++;
         tick();
         edges++;
      end
      check({tag, "_latency"}, edges, lat);
      check({tag, "_stall_cycles"}, stalls, lat);
      check({tag, "_x1_held"}, fpu_x1, x1);
      check({tag, "_x2_held"}, fpu_x2, x2);
      check({tag, "_cont_held"}, fpu_cont, cont);
   endtask

   // Let writeback take the pending result and confirm the sequencer goes idle.
   task automatic drain(input string tag);
      wb_ready = 1'b1;
      #1;
      check({tag, "_done_no_stall"}, stall, 0);
      consume(tag);
      tick();
      check({tag, "_idle_valid"}, res_valid, 0);
      check({tag, "_idle_state"}, state_dbg, ST_IDLE);
      check({tag, "_idle_cont"}, fpu_cont, 0);
   endtask

   logic [4:0]  tbl_cont[6] = '{FSUB, FCVTSW, FCVTWS, 5'b11011, 5'b11111, FSGNJ};
   int          tbl_lat[6]  = '{3, 2, 2, 1, 1, 1};

   initial begin
      logic seen;
      idle_inputs();

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", state_dbg, ST_IDLE);
      check("rst_res_valid", res_valid, 0);
      check("rst_fpu_cont", fpu_cont, 0);
      check("rst_res_data", res_data, 0);
      check("rst_stall", stall, 0);
      check("rst_req_ready", req_ready, 1);
      rst = 1'b0;
      tick();

      // 1: fadd 1.0 + 2.0 = 3.0
      run_op(FADD, 32'h3F800000, 32'h40000000, 5'd5, 32'h40400000, 3, "fadd");
      drain("fadd");

      // 2: fdiv, then fmul accepted on the fdiv retire edge
      run_op(FDIV, 32'h3F800000, 32'h40000000, 5'd7, 32'h3F000000, 10, "fdiv");
      run_op(FMUL, 32'h40000000, 32'h40A00000, 5'd9, 32'h41200000, 2, "fmul");
      drain("fmul");

      // 3: feq result held under writeback backpressure
      wb_ready = 1'b0;
      run_op(FEQ, 32'h3F800000, 32'h3F800000, 5'd3, 32'h00000001, 1, "feq");
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1;
         req_cont  = FADD;
         req_x1    = 32'h11111111;
         fpu_y     = 32'hDEADBEEF;
         #1;
         check("bp_res_valid", res_valid, 1);
         check("bp_res_data", res_data, 32'h00000001);
         check("bp_stall", stall, 1);
         check("bp_req_ready", req_ready, 0);
         check("bp_not_accepted", fpu_cont, FEQ);
         tick();
      end
      wb_ready = 1'b1;
      run_op(FADD, 32'h40000000, 32'h40400000, 5'd4, 32'h40A00000, 3, "fadd2");
      drain("fadd2");

      // 4: flush an fsqrt mid-flight
      req_valid = 1'b1;
      req_cont  = FSQRT;
      req_x1    = 32'h40800000;
      req_rd    = 5'd12;
      fpu_y     = 32'h40000000;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      check("flush_state", state_dbg, ST_IDLE);
      check("flush_cont", fpu_cont, 0);
      check("flush_res_valid", res_valid, 0);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (res_valid) seen = 1'b1;
         tick();
      end
      check("flush_no_result", seen, 0);
      // flush also blocks an accept in the same cycle
      req_valid = 1'b1;
      req_cont  = FADD;
      flush     = 1'b1;
      tick();
      req_valid = 1'b0;
      flush     = 1'b0;
      #1;
      check("flush_blocks_accept", state_dbg, ST_IDLE);
      check("flush_blocks_cont", fpu_cont, 0);

      // 5: asynchronous reset while busy
      req_valid = 1'b1;
      req_cont  = FADD;
      req_x1    = 32'h12345678;
      req_x2    = 32'h9ABCDEF0;
      req_rd    = 5'd6;
      tick();
      req_valid = 1'b0;
      tick();
      check("pre_rst_busy", state_dbg, ST_BUSY);
      rst = 1'b1;
      #1;
      check("arst_state", state_dbg, ST_IDLE);
      check("arst_x1", fpu_x1, 0);
      check("arst_x2", fpu_x2, 0);
      check("arst_cont", fpu_cont, 0);
      check("arst_rd", res_rd, 0);
      check("arst_data", res_data, 0);
      check("arst_stall", stall, 0);
      #1;
      rst = 1'b0;
      tick();
      run_op(FADD, 32'h3F800000, 32'h3F800000, 5'd8, 32'h40000000, 3, "fadd_after_rst");
      drain("fadd_after_rst");

      // 6: non-FPU code is ignored
      req_valid = 1'b1;
      req_cont  = 5'b00000;
      #1;
      check("nonfpu_stall", stall, 0);
      tick();
      check("nonfpu_state", state_dbg, ST_IDLE);
      check("nonfpu_cont", fpu_cont, 0);
      req_valid = 1'b0;

      // Latency table: fsub, conversions, unlisted codes, sign injection
      for (int i = 0; i < 6; i++) begin
         run_op(tbl_cont[i], 32'h00000100 + 32'(i), 32'h00000200 + 32'(i), 5'(16 + i),
                32'hA0000000 + 32'(i), tbl_lat[i], $sformatf("tbl%0d", i));
      end
      drain("tbl_last");

      check("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
